// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants for the data-memory responder slice: the data word width,
// the number of byte lanes in a word, and the responder FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int WORD_W    = 32;
   localparam int NUM_LANES = WORD_W / 8;

   // Responder FSM states.
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_WAIT = 2'd1;
   localparam state_t ST_RESP = 2'd2;

endpackage : dmem_pkg

// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the CPU load/store path (master) and the
// data-memory responder (slave).
//   req_valid_i / req_ready_o   request handshake
//   req_we_i, req_addr_i, req_wdata_i (and req_be_i when DMEM_BYTE_STROBE_EN
//   is defined)                 request payload
//   resp_valid_o / resp_ready_i response handshake
//   resp_rdata_o, resp_err_o    response payload
// Suffixes are from the responder's point of view.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. The sender raises valid independently of
// ready and holds valid plus its payload stable until that edge; ready may
// depend on the receiver's state but never on valid of the same channel.
// -----------------------------------------------------------------------------
interface dmem_if;
   import dmem_pkg::*;

   logic                 req_valid_i;
   logic                 req_ready_o;
   logic                 req_we_i;
   logic [WORD_W-1:0]    req_addr_i;
   logic [WORD_W-1:0]    req_wdata_i;
`ifdef DMEM_BYTE_STROBE_EN
   logic [NUM_LANES-1:0] req_be_i;
`endif
   logic                 resp_valid_o;
   logic                 resp_ready_i;
   logic [WORD_W-1:0]    resp_rdata_o;
   logic                 resp_err_o;

   modport slave (
      input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
`ifdef DMEM_BYTE_STROBE_EN
      input  req_be_i,
`endif
      output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

   modport master (
      output req_valid_i, req_we_i, req_addr_i, req_wdata_i, resp_ready_i,
`ifdef DMEM_BYTE_STROBE_EN
      output req_be_i,
`endif
      input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
   );

endinterface : dmem_if

// File: rtl/dmem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// DEPTH x 32-bit storage. Writes are synchronous with per-byte enables; the
// read port is combinational so the responder can capture load data on the
// same edge that a store would commit. Contents are not reset.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   waddr_i  write word index
//   wbe_i    per-byte write enables (bit n = byte n)
//   wdata_i  write data
//   raddr_i  read word index
//   rdata_o  read data
// -----------------------------------------------------------------------------
module dmem_array
   import dmem_pkg::*;
#(
   parameter  int DEPTH = 1024,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 we_i,
   input  logic [AW-1:0]        waddr_i,
   input  logic [NUM_LANES-1:0] wbe_i,
   input  logic [WORD_W-1:0]    wdata_i,
   input  logic [AW-1:0]        raddr_i,
   output logic [WORD_W-1:0]    rdata_o
);

   logic [WORD_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            if (wbe_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Memory-side responder for CPU data loads/stores: one outstanding request,
// fixed access latency, valid/ready request and response channels.
// Optional feature macro: DMEM_BYTE_STROBE_EN (adds req_be_i; stores write
// only strobed bytes). Without it every store writes the full word.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    asynchronous reset, active low
//   bus      dmem_if.slave request/response channels
//   busy_o   high while a transaction is in WAIT or RESP
//   state_o  current FSM state (debug)
// Parameters:
//   DEPTH    words of storage (word index = addr[31:2])
//   LATENCY  edges from request accept to resp_valid_o, 1..15
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter  int DEPTH   = 1024,
   parameter  int LATENCY = 2,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic   clk_i,
   input  logic   rst_i,
   dmem_if.slave  bus,
   output logic   busy_o,
   output state_t state_o
);

   state_t               state_q, state_d;
   logic [3:0]           cnt_q, cnt_d;
   logic                 we_q;
   logic [WORD_W-1:0]    addr_q, wdata_q;
   logic [WORD_W-1:0]    rdata_q, rdata_d;
   logic                 err_q, err_d;
   logic [NUM_LANES-1:0] wr_be;
   logic                 lat_en, mem_we, acc_err;
   logic [WORD_W-1:0]    mem_rdata;
   logic [AW-1:0]        word_idx;

   // Misaligned or beyond the last word; either way the array is untouched.
   assign acc_err  = (addr_q[1:0] != 2'b00) ||
                     ({2'b00, addr_q[WORD_W-1:2]} >= 32'(DEPTH));
   assign word_idx = addr_q[AW+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      lat_en  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_valid_i) begin
               lat_en  = 1'b1;
               cnt_d   = 4'(LATENCY - 1);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               // Access executes on this edge: store commits, response captured.
               mem_we  = we_q && !acc_err;
               rdata_d = (we_q || acc_err) ? '0 : mem_rdata;
               err_d   = acc_err;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (bus.resp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   // Request payload is captured only on the accept edge.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (lat_en) begin
         we_q    <= bus.req_we_i;
         addr_q  <= bus.req_addr_i;
         wdata_q <= bus.req_wdata_i;
      end
   end

`ifdef DMEM_BYTE_STROBE_EN
   logic [NUM_LANES-1:0] be_q;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)      be_q <= '0;
      else if (lat_en) be_q <= bus.req_be_i;
   end

   assign wr_be = be_q;
`else
   assign wr_be = '1;
`endif

   dmem_array #(.DEPTH(DEPTH)) u_array (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (word_idx),
      .wbe_i   (wr_be),
      .wdata_i (wdata_q),
      .raddr_i (word_idx),
      .rdata_o (mem_rdata)
   );

   assign bus.req_ready_o  = (state_q == ST_IDLE);
   assign bus.resp_valid_o = (state_q == ST_RESP);
   assign bus.resp_rdata_o = rdata_q;
   assign bus.resp_err_o   = err_q;
   assign busy_o           = (state_q == ST_WAIT) || (state_q == ST_RESP);
   assign state_o          = state_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder (DEPTH=1024, LATENCY=2): store/load
// round trip, response back-pressure, misaligned and out-of-range errors,
// ignored requests while busy, reset during WAIT, and the byte-strobe store.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int LAT = 2;

   // ---------------- clock / reset ----------------
   logic   clk = 1'b0;
   logic   rst_n;
   logic   busy;
   state_t st;

   always #5 clk = ~clk;

   dmem_if bus ();

   dmem_responder #(.DEPTH(1024), .LATENCY(LAT)) dut (
      .clk_i   (clk),
      .rst_i   (rst_n),
      .bus     (bus),
      .busy_o  (busy),
      .state_o (st)
   );

   // ---------------- bookkeeping ----------------
   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a request and return just after the edge that accepts it.
   task automatic send(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
      int guard = 0;
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = we;
      bus.req_addr_i  = addr;
      bus.req_wdata_i = wdata;
`ifdef DMEM_BYTE_STROBE_EN
      bus.req_be_i    = be;
`else
      if (be != 4'hF) $info("byte strobes ignored in this build");
`endif
      while (!bus.req_ready_o && guard < 20) begin
         tick();
         guard++;
      end
      if (guard >= 20) chk("req_ready_timeout", 32'(guard), 32'd0);
      tick();
      bus.req_valid_i = 1'b0;
   endtask

   // Count edges until resp_valid_o is seen (bounded).
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!bus.resp_valid_o && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   task automatic take_resp();
      bus.resp_ready_i = 1'b1;
      tick();
      bus.resp_ready_i = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   int          lat;
   logic [31:0] exp_strobe;

   initial begin
      bus.req_valid_i  = 1'b0;
      bus.req_we_i     = 1'b0;
      bus.req_addr_i   = '0;
      bus.req_wdata_i  = '0;
`ifdef DMEM_BYTE_STROBE_EN
      bus.req_be_i     = 4'hF;
`endif
      bus.resp_ready_i = 1'b0;
      rst_n            = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_req_ready",  32'(bus.req_ready_o),  32'd1);
      chk("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("rst_rdata",      bus.resp_rdata_o,      32'd0);
      chk("rst_err",        32'(bus.resp_err_o),   32'd0);
      chk("rst_busy",       32'(busy),             32'd0);
      chk("rst_state",      32'(st),               32'(ST_IDLE));
      rst_n = 1'b1;
      tick();

      // 1. Store then load, LATENCY=2
      send(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      chk("t1_st_busy", 32'(busy), 32'd1);
      wait_resp(lat);
      chk("t1_st_lat",   32'(lat),              32'(LAT));
      chk("t1_st_rdata", bus.resp_rdata_o,      32'd0);
      chk("t1_st_err",   32'(bus.resp_err_o),   32'd0);
      take_resp();
      chk("t1_st_done_valid", 32'(bus.resp_valid_o), 32'd0);
      send(1'b0, 32'h10, 32'h0, 4'hF);
      wait_resp(lat);
      chk("t1_ld_lat",   32'(lat),            32'(LAT));
      chk("t1_ld_rdata", bus.resp_rdata_o,    32'hDEADBEEF);
      chk("t1_ld_err",   32'(bus.resp_err_o), 32'd0);
      take_resp();

      // 2. Load with response back-pressure
      send(1'b0, 32'h10, 32'h0, 4'hF);
      wait_resp(lat);
      chk("t2_lat", 32'(lat), 32'(LAT));
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 32'(bus.resp_valid_o), 32'd1);
         chk("t2_hold_rdata", bus.resp_rdata_o,      32'hDEADBEEF);
         chk("t2_hold_ready", 32'(bus.req_ready_o),  32'd0);
         tick();
      end
      take_resp();
      chk("t2_after_ready", 32'(bus.req_ready_o),  32'd1);
      chk("t2_after_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("t2_after_busy",  32'(busy),             32'd0);

      // 3. Misaligned store errors, array unchanged
      send(1'b1, 32'h13, 32'h11111111, 4'hF);
      wait_resp(lat);
      chk("t3_err",   32'(bus.resp_err_o), 32'd1);
      chk("t3_rdata", bus.resp_rdata_o,    32'd0);
      take_resp();
      send(1'b0, 32'h10, 32'h0, 4'hF);
      wait_resp(lat);
      chk("t3_ld_rdata", bus.resp_rdata_o,    32'hDEADBEEF);
      chk("t3_ld_err",   32'(bus.resp_err_o), 32'd0);
      take_resp();

      // 4. Out-of-range load; a request pulsed during WAIT is ignored
      send(1'b0, 32'h1000, 32'h0, 4'hF);
      bus.req_valid_i = 1'b1;
      bus.req_we_i    = 1'b1;
      bus.req_addr_i  = 32'h20;
      bus.req_wdata_i = 32'h55555555;
      chk("t4_wait_state", 32'(st),              32'(ST_WAIT));
      chk("t4_wait_ready", 32'(bus.req_ready_o), 32'd0);
      tick();
      bus.req_valid_i = 1'b0;
      wait_resp(lat);
      chk("t4_err",   32'(bus.resp_err_o), 32'd1);
      chk("t4_rdata", bus.resp_rdata_o,    32'd0);
      take_resp();
      tick();
      tick();
      chk("t4_no_latch_state", 32'(st),   32'(ST_IDLE));
      chk("t4_no_latch_busy",  32'(busy), 32'd0);

      // 5. Reset during WAIT drops the store
      send(1'b1, 32'h10, 32'hCAFEF00D, 4'hF);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 32'(bus.req_ready_o),  32'd1);
      chk("t5_rst_valid", 32'(bus.resp_valid_o), 32'd0);
      chk("t5_rst_rdata", bus.resp_rdata_o,      32'd0);
      chk("t5_rst_err",   32'(bus.resp_err_o),   32'd0);
      chk("t5_rst_busy",  32'(busy),             32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      send(1'b0, 32'h10, 32'h0, 4'hF);
      wait_resp(lat);
      chk("t5_ld_rdata", bus.resp_rdata_o, 32'hDEADBEEF);
      take_resp();

      // 6. Byte-strobed store over 0xDEADBEEF
`ifdef DMEM_BYTE_STROBE_EN
      exp_strobe = 32'hDEAD5678;
`else
      exp_strobe = 32'h12345678;
`endif
      send(1'b1, 32'h10, 32'h12345678, 4'b0011);
      wait_resp(lat);
      chk("t6_st_rdata", bus.resp_rdata_o, 32'd0);
      take_resp();
      send(1'b0, 32'h10, 32'h0, 4'hF);
      wait_resp(lat);
      chk("t6_ld_rdata", bus.resp_rdata_o,    exp_strobe);
      chk("t6_ld_err",   32'(bus.resp_err_o), 32'd0);
      take_resp();

      // ---------------- report ----------------
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule : tb_dmem_responder
